// File: rtl/hamming_secded_decoder.sv
// Two-stage pipelined SECDED Hamming decoder with valid/ready flow control.
// Define HAMMING_DEC_ERR_CNT_EN to build the saturating corrected/uncorrected word counters.
module hamming_secded_decoder #(
  parameter  int DATA_WIDTH = 16,
  parameter  int CNT_WIDTH  = 16,
  localparam int P          = (DATA_WIDTH <= 4)  ? 3 :
                              (DATA_WIDTH <= 11) ? 4 :
                              (DATA_WIDTH <= 26) ? 5 :
                              (DATA_WIDTH <= 57) ? 6 : 7,
  localparam int ENC_WIDTH  = DATA_WIDTH + P + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ENC_WIDTH-1:0]  in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  err_single,
  output logic                  err_double,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  corr_count,
  output logic [CNT_WIDTH-1:0]  uncorr_count
);

  logic                  adv;
  logic [P-1:0]          syn_d;
  logic                  ovp_d;
  logic                  s1_valid_q;
  logic [ENC_WIDTH-1:0]  s1_cw_q;
  logic [P-1:0]          s1_syn_q;
  logic                  s1_ovp_q;
  logic [ENC_WIDTH-1:0]  flip_d;
  logic [ENC_WIDTH-1:0]  corr_cw_d;
  logic                  single_d;
  logic                  double_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  err_single_q;
  logic                  err_double_q;
  logic                  unused_cw_bits;

  // The whole pipeline moves as one unit whenever the output slot can be refilled.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    syn_d = '0;
    for (int i = 0; i < ENC_WIDTH - 1; i++) begin
      for (int k = 0; k < P; k++) begin
        if ((((i + 1) >> k) & 1) != 0) syn_d[k] = syn_d[k] ^ in_data[i];
      end
    end
    ovp_d = ^in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_cw_q    <= '0;
      s1_syn_q   <= '0;
      s1_ovp_q   <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      s1_cw_q    <= in_data;
      s1_syn_q   <= syn_d;
      s1_ovp_q   <= ovp_d;
    end
  end

  // A syndrome beyond the last codeword position leaves flip_d empty: not correctable.
  always_comb begin
    flip_d = '0;
    for (int i = 0; i < ENC_WIDTH - 1; i++) begin
      if (int'(s1_syn_q) == i + 1) flip_d[i] = 1'b1;
    end
    single_d  = 1'b0;
    double_d  = 1'b0;
    corr_cw_d = s1_cw_q;
    if (s1_syn_q == '0) begin
      single_d = s1_ovp_q;
    end else if (s1_ovp_q && (flip_d != '0)) begin
      single_d  = 1'b1;
      corr_cw_d = s1_cw_q ^ flip_d;
    end else begin
      double_d = 1'b1;
    end
  end

  // Data bits occupy the non-power-of-two positions in ascending order.
  for (genvar pos = 1; pos < ENC_WIDTH; pos++) begin : g_extract
    if ((pos & (pos - 1)) != 0) begin : g_data
      assign data_d[pos - 1 - $clog2(pos + 1)] = corr_cw_d[pos - 1];
    end
  end

  assign unused_cw_bits = ^corr_cw_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      err_single_q <= 1'b0;
      err_double_q <= 1'b0;
    end else if (adv) begin
      out_valid_q  <= s1_valid_q;
      out_data_q   <= data_d;
      err_single_q <= s1_valid_q && single_d;
      err_double_q <= s1_valid_q && double_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign err_single = err_single_q;
  assign err_double = err_double_q;

`ifdef HAMMING_DEC_ERR_CNT_EN
  logic                 out_xfer;
  logic [CNT_WIDTH-1:0] corr_q;
  logic [CNT_WIDTH-1:0] uncorr_q;

  assign out_xfer = out_valid_q && out_ready;

  // Counters saturate at all-ones; a clear takes priority over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_q   <= '0;
      uncorr_q <= '0;
    end else if (cnt_clr) begin
      corr_q   <= '0;
      uncorr_q <= '0;
    end else begin
      if (out_xfer && err_single_q && (corr_q != '1))   corr_q   <= corr_q + 1'b1;
      if (out_xfer && err_double_q && (uncorr_q != '1)) uncorr_q <= uncorr_q + 1'b1;
    end
  end

  assign corr_count   = corr_q;
  assign uncorr_count = uncorr_q;
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign corr_count     = '0;
  assign uncorr_count   = '0;
`endif

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Directed-vector bench for hamming_secded_decoder (16-bit data, 2-bit counters to reach saturation).
module tb_hamming_secded_decoder;

  localparam int DW = 16;
  localparam int CW = 2;
  localparam int EW = 22;
  localparam int CNT_MAX = 3;
`ifdef HAMMING_DEC_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [EW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          err_single;
  logic          err_double;
  logic          cnt_clr;
  logic [CW-1:0] corr_count;
  logic [CW-1:0] uncorr_count;

  int n_checks = 0;
  int n_pass   = 0;
  int corr_exp = 0;
  int uncorr_exp = 0;

  hamming_secded_decoder #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .err_single   (err_single),
    .err_double   (err_double),
    .cnt_clr      (cnt_clr),
    .corr_count   (corr_count),
    .uncorr_count (uncorr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_corr_cnt"},   corr_count,   CNT_EN ? corr_exp   : 0);
    check({tag, "_uncorr_cnt"}, uncorr_count, CNT_EN ? uncorr_exp : 0);
  endtask

  // Reference encoder: data into non-power-of-two positions, then Hamming and overall parity.
  function automatic logic [EW-1:0] encode(input logic [DW-1:0] d);
    logic [EW-1:0] cw = '0;
    int j = 0;
    logic p;
    for (int pos = 1; pos < EW; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos-1] = d[j];
        j++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      p = 1'b0;
      for (int pos = 1; pos < EW; pos++) if ((pos & (1 << k)) != 0) p ^= cw[pos-1];
      cw[(1 << k) - 1] = p;
    end
    cw[EW-1] = ^cw[EW-2:0];
    return cw;
  endfunction

  // One isolated word: accept, check 2-cycle latency and flags, transfer, check counters/bubble.
  task automatic send_word(input string tag, input logic [EW-1:0] cw, input logic [DW-1:0] exp_data,
                           input logic exp_s, input logic exp_d, input logic clr);
    check({tag, "_in_ready"}, in_ready, 1);
    in_data   = cw;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
    check({tag, "_lat1_valid"}, out_valid, 0);
    @(posedge clk); #1;
    check({tag, "_lat2_valid"}, out_valid, 1);
    check({tag, "_data"}, out_data, exp_data);
    check({tag, "_single"}, err_single, exp_s);
    check({tag, "_double"}, err_double, exp_d);
    cnt_clr = clr;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    if (clr) begin
      corr_exp   = 0;
      uncorr_exp = 0;
    end else begin
      if (exp_s && corr_exp < CNT_MAX)   corr_exp++;
      if (exp_d && uncorr_exp < CNT_MAX) uncorr_exp++;
    end
    check_counts(tag);
    check({tag, "_bubble_valid"}, out_valid, 0);
    check({tag, "_bubble_flags"}, {err_single, err_double}, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [EW-1:0] a5;
    logic [DW-1:0] words [4];
    logic [DW-1:0] held;
    bit            have_held;
    int            sent;
    int            rcv;

    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_flags", {err_single, err_double}, 2'b00);
    check("rst_corr_cnt", corr_count, 0);
    check("rst_uncorr_cnt", uncorr_count, 0);
    rst = 1'b0;
    #1;
    check("rst_release_in_ready", in_ready, 1);
    @(posedge clk); #1;

    a5 = encode(16'hA5C3);
    send_word("clean",     a5,                    16'hA5C3, 1'b0, 1'b0, 1'b0);
    send_word("sgl_bit4",  a5 ^ (22'd1 << 4),     16'hA5C3, 1'b1, 1'b0, 1'b0);
    send_word("sgl_ovp",   a5 ^ (22'd1 << 21),    16'hA5C3, 1'b1, 1'b0, 1'b0);
    // Positions 3 and 10 flipped: data bits 0 and 5 stay inverted in the raw extraction.
    send_word("dbl_2_9",   encode(16'h1234) ^ (22'd1 << 2) ^ (22'd1 << 9), 16'h1215, 1'b0, 1'b1, 1'b0);
    // Positions 16, 8 and 1 flipped: syndrome 25 lies past the codeword, parity bits only.
    send_word("dbl_synhi", encode(16'hBEEF) ^ (22'd1 << 15) ^ (22'd1 << 7) ^ (22'd1 << 0),
              16'hBEEF, 1'b0, 1'b1, 1'b0);

    words     = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    sent      = 0;
    rcv       = 0;
    have_held = 1'b0;
    held      = '0;
    for (int n = 0; n < 20 && rcv < 4; n++) begin
      out_ready = !(n >= 2 && n <= 4);
      in_valid  = (sent < 4);
      in_data   = (sent < 4) ? encode(words[sent]) : '0;
      @(negedge clk);
      if (n == 2) check("stall_out_valid", out_valid, 1);
      if (out_valid && !out_ready) begin
        check("stall_in_ready", in_ready, 0);
        if (have_held) check("stall_hold_data", out_data, held);
        held      = out_data;
        have_held = 1'b1;
      end
      if (out_valid && out_ready) begin
        check($sformatf("stall_order%0d", rcv), out_data, words[rcv]);
        check($sformatf("stall_flags%0d", rcv), {err_single, err_double}, 2'b00);
        rcv++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stall_delivered", rcv, 4);
    check("stall_accepted", sent, 4);
    check_counts("stall");

    for (int n = 0; n < 5; n++) begin
      send_word($sformatf("sat%0d", n), encode(16'(16'h0F0F + n)) ^ (22'd1 << (n * 3)),
                16'(16'h0F0F + n), 1'b1, 1'b0, 1'b0);
    end
    send_word("clr_wins", encode(16'h5555) ^ (22'd1 << 10), 16'h5555, 1'b1, 1'b0, 1'b1);

    in_data  = encode(16'h7777) ^ (22'd1 << 4);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = encode(16'h8888);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("inflight_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    corr_exp   = 0;
    uncorr_exp = 0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_flags", {err_single, err_double}, 2'b00);
    check_counts("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      check($sformatf("post_rst_quiet%0d", n), out_valid, 0);
    end
    check_counts("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
